// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave power timer.
// Segment codes are active-high in gfedcba bit order.
package microwave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int QUICK_START_SECS = 30;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to 7-segment decoder; non-decimal codes blank.
module bcd_to_seg7
  import microwave_pkg::*;
(
  input  bcd_t       bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/microwave_pwr_timer.sv
// Microwave controller: BCD keypad entry, per-second countdown, duty-cycled magnetron.
// Optional quick-start (+30 s on start) is enabled by defining MW_QUICK_START_EN.
module microwave_pwr_timer
  import microwave_pkg::*;
#(
  parameter int CLK_HZ       = 100,
  parameter int MIN_DIGITS   = 2,
  parameter int POWER_LEVELS = 10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [9:0]                            kbd,
  input  logic                                  startn,
  input  logic                                  stopn,
  input  logic                                  clearn,
  input  logic                                  pwr_keyn,
  input  logic                                  door_closed,
  output logic [6:0]                            sec_ones_seg,
  output logic [6:0]                            sec_tens_seg,
  output logic [7*MIN_DIGITS-1:0]               min_segs,
  output logic [$clog2(POWER_LEVELS+1)-1:0]     pwr_level,
  output logic                                  mag_on,
  output logic                                  done
);

  localparam int NDIG  = MIN_DIGITS + 2;
  localparam int LVL_W = $clog2(POWER_LEVELS + 1);
  localparam int PS_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int WIN_W = (POWER_LEVELS > 1) ? $clog2(POWER_LEVELS) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLK_HZ - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(POWER_LEVELS - 1);
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(POWER_LEVELS);
`ifdef MW_QUICK_START_EN
  localparam bit QS_EN = 1'b1;
`else
  localparam bit QS_EN = 1'b0;
`endif

  // digit 0 = seconds ones, 1 = seconds tens, 2.. = minutes
  typedef logic [NDIG-1:0][3:0] time_t;

  state_e             state_q, state_d;
  time_t              time_q, time_d, t_next;
  logic [LVL_W-1:0]   lvl_q, lvl_d, lvl_step;
  logic [PS_W-1:0]    presc_q, presc_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic               done_q, done_d;
  logic               startn_q, stopn_q, clearn_q, pwrn_q;
  logic [9:0]         kbd_q;
  logic               start_ev, stop_ev, clear_ev, pwr_ev, dig_ev, kbd_onehot, tick;
  logic [3:0]         dig_val;

  function automatic time_t dec_time(input time_t t);
    time_t r;
    logic  borrow;
    r      = t;
    borrow = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (borrow) begin
        if (r[i] == 4'd0) begin
          r[i] = (i == 1) ? 4'd5 : 4'd9;
        end else begin
          r[i]   = r[i] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Adds the quick-start amount, carrying seconds >= 60 into minutes; saturates at all 9s.
  function automatic time_t add_qs(input time_t t);
    time_t      r;
    logic       carry;
    logic [3:0] tens;
    r     = t;
    carry = (t[0] >= 4'(10 - QUICK_START_SECS % 10));
    r[0]  = carry ? t[0] - 4'(10 - QUICK_START_SECS % 10) : t[0] + 4'(QUICK_START_SECS % 10);
    tens  = t[1] + 4'(QUICK_START_SECS / 10) + {3'd0, carry};
    carry = (tens >= 4'd6);
    r[1]  = carry ? tens - 4'd6 : tens;
    for (int i = 2; i < NDIG; i++) begin
      if (carry) begin
        if (r[i] == 4'd9) begin
          r[i] = 4'd0;
        end else begin
          r[i]  = r[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (carry) r = {NDIG{4'd9}};
    return r;
  endfunction

  function automatic time_t qs_time();
    time_t r;
    r    = '0;
    r[0] = 4'(QUICK_START_SECS % 10);
    r[1] = 4'(QUICK_START_SECS / 10);
    return r;
  endfunction

  assign start_ev   = startn_q & ~startn;
  assign stop_ev    = stopn_q & ~stopn;
  assign clear_ev   = clearn_q & ~clearn;
  assign pwr_ev     = pwrn_q & ~pwr_keyn;
  assign kbd_onehot = (kbd != 10'd0) && ((kbd & (kbd - 10'd1)) == 10'd0);
  assign dig_ev     = kbd_onehot && (kbd_q == 10'd0);
  assign tick       = (state_q == ST_COOK) && (presc_q == PS_LAST);
  assign lvl_step   = (lvl_q == LVL_MAX) ? LVL_W'(1) : lvl_q + LVL_W'(1);

  always_comb begin
    dig_val = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (kbd[i]) dig_val = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    lvl_d   = lvl_q;
    presc_d = presc_q;
    win_d   = win_q;
    done_d  = 1'b0;
    t_next  = time_q;
    if (clear_ev) begin
      state_d = ST_IDLE;
      time_d  = '0;
      lvl_d   = LVL_MAX;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (stop_ev) begin
            state_d = ST_IDLE;
          end else if (start_ev) begin
            if (QS_EN && door_closed) begin
              state_d = ST_COOK;
              time_d  = qs_time();
              presc_d = '0;
              win_d   = '0;
            end
          end else if (pwr_ev) begin
            lvl_d = lvl_step;
          end else if (dig_ev) begin
            time_d  = {time_q[NDIG-2:0], dig_val};
            state_d = ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (stop_ev) begin
            state_d = ST_ENTRY;
          end else if (start_ev) begin
            if (door_closed && (time_q != '0)) begin
              state_d = ST_COOK;
              presc_d = '0;
              win_d   = '0;
            end
          end else if (pwr_ev) begin
            lvl_d = lvl_step;
          end else if (dig_ev) begin
            time_d = {time_q[NDIG-2:0], dig_val};
          end
        end
        ST_COOK: begin
          // A pausing cycle does not advance the prescaler, so resume picks up exactly.
          if (stop_ev || !door_closed) begin
            state_d = ST_PAUSE;
          end else begin
            if (tick) begin
              t_next  = dec_time(time_q);
              presc_d = '0;
              win_d   = (win_q == WIN_LAST) ? '0 : win_q + WIN_W'(1);
            end else begin
              presc_d = presc_q + PS_W'(1);
            end
            if (QS_EN && start_ev) t_next = add_qs(t_next);
            time_d = t_next;
            if (t_next == '0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (stop_ev) begin
            state_d = ST_IDLE;
            time_d  = '0;
          end else if (start_ev && door_closed) begin
            state_d = ST_COOK;
          end
        end
        ST_DONE: begin
          if (stop_ev || start_ev || pwr_ev || dig_ev || !door_closed) begin
            state_d = ST_IDLE;
            time_d  = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      time_q   <= '0;
      lvl_q    <= LVL_MAX;
      presc_q  <= '0;
      win_q    <= '0;
      done_q   <= 1'b0;
      startn_q <= 1'b1;
      stopn_q  <= 1'b1;
      clearn_q <= 1'b1;
      pwrn_q   <= 1'b1;
      kbd_q    <= '0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      lvl_q    <= lvl_d;
      presc_q  <= presc_d;
      win_q    <= win_d;
      done_q   <= done_d;
      startn_q <= startn;
      stopn_q  <= stopn;
      clearn_q <= clearn;
      pwrn_q   <= pwr_keyn;
      kbd_q    <= kbd;
    end
  end

  assign mag_on    = (state_q == ST_COOK) && door_closed && (LVL_W'(win_q) < lvl_q);
  assign done      = done_q;
  assign pwr_level = lvl_q;

  bcd_to_seg7 u_sec_ones (.bcd_i(time_q[0]), .seg_o(sec_ones_seg));
  bcd_to_seg7 u_sec_tens (.bcd_i(time_q[1]), .seg_o(sec_tens_seg));

  for (genvar g = 0; g < MIN_DIGITS; g++) begin : g_min
    bcd_to_seg7 u_min (.bcd_i(time_q[g+2]), .seg_o(min_segs[7*g +: 7]));
  end

endmodule
